mis603_soc_bram_port_arbiter: RTL and testbench

//  Shares one port (port B) of the MicroBlaze local-memory BRAM block between two requesters, M0 and M1 (e.g. loader DMA and debug reader).

---
 rtl/mis603_soc_bram_arb_pkg.sv | 25 ++
 rtl/mis603_soc_bram_arb_rr.sv | 47 ++++
 rtl/mis603_soc_bram_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mis603_soc_bram_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mis603_soc_bram_arb_pkg.sv
// Shared types for the BRAM port-B arbiter: FSM encoding, owner ids, read-return tag.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mis603_soc_bram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_OWN_M0 = 2'd1,
    ST_OWN_M1 = 2'd2
  } arb_state_e;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  // One entry of the read-return pipe: a read is in flight and who asked for it.
  typedef struct packed {
    logic vld;
    logic owner;
  } rd_tag_t;

  function automatic logic other_owner(input logic owner);
    return ~owner;
  endfunction

endpackage

// File: rtl/mis603_soc_bram_arb_rr.sv
// Two-way round-robin picker with burst lock; pure combinational grant select.
// Latency: 0 cycles (req -> gnt in the same cycle).
// Backpressure: a requester without gnt simply waits; gnt never asserts without req.
module mis603_soc_bram_arb_rr
  import mis603_soc_bram_arb_pkg::*;
#(
  parameter int C_MAX_BURST = 4,
  parameter int BW          = 3
) (
  input  logic [1:0]    req_i,
  input  arb_state_e    state_i,
  input  logic          last_owner_i,
  input  logic [BW-1:0] burst_cnt_i,
  output logic [1:0]    gnt_o
);

  localparam logic [BW-1:0] MAX_B = BW'(C_MAX_BURST);

  logic own;
  logic oth;

  // Current owner keeps the port until its burst allowance runs out while the other waits.
  always_comb begin
    gnt_o = 2'b00;
    own   = (state_i == ST_OWN_M1) ? OWNER_M1 : OWNER_M0;
    oth   = other_owner(own);
    case (state_i)
      ST_OWN_M0, ST_OWN_M1: begin
        if (req_i[own] && (!req_i[oth] || (burst_cnt_i < MAX_B))) begin
          gnt_o[own] = 1'b1;
        end else if (req_i[oth]) begin
          gnt_o[oth] = 1'b1;
        end
      end
      default: begin
        if (req_i[0] && !req_i[1]) begin
          gnt_o[0] = 1'b1;
        end else if (req_i[1] && !req_i[0]) begin
          gnt_o[1] = 1'b1;
        end else if (req_i[0] && req_i[1]) begin
          gnt_o[other_owner(last_owner_i)] = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/mis603_soc_bram_port_arbiter.sv
// Shares BRAM port B between M0 and M1: round-robin with bounded burst, registered BRAM drive.
// Latency: transfer at edge T -> BRAM controls in T+1, read data + RValid in T+2.
// Backpressure: combinational Gnt; requester holds Req/controls stable until granted.
module mis603_soc_bram_port_arbiter
  import mis603_soc_bram_arb_pkg::*;
#(
  parameter int C_PORT_AWIDTH = 32,
  parameter int C_PORT_DWIDTH = 32,
  parameter int C_NUM_WE      = 4,
  parameter int C_MAX_BURST   = 4,
  parameter     C_FAMILY      = "spartan6"
) (
  input  logic                     BRAM_Clk,
  input  logic                     BRAM_Rst_N,
  input  logic                     M0_Req,
  input  logic [0:C_NUM_WE-1]      M0_WE,
  input  logic [0:C_PORT_AWIDTH-1] M0_Addr,
  input  logic [0:C_PORT_DWIDTH-1] M0_WData,
  output logic                     M0_Gnt,
  output logic                     M0_RValid,
  output logic [0:C_PORT_DWIDTH-1] M0_RData,
  input  logic                     M1_Req,
  input  logic [0:C_NUM_WE-1]      M1_WE,
  input  logic [0:C_PORT_AWIDTH-1] M1_Addr,
  input  logic [0:C_PORT_DWIDTH-1] M1_WData,
  output logic                     M1_Gnt,
  output logic                     M1_RValid,
  output logic [0:C_PORT_DWIDTH-1] M1_RData,
  output logic                     BRAM_EN,
  output logic [0:C_NUM_WE-1]      BRAM_WEN,
  output logic [0:C_PORT_AWIDTH-1] BRAM_Addr,
  output logic [0:C_PORT_DWIDTH-1] BRAM_Dout,
  input  logic [0:C_PORT_DWIDTH-1] BRAM_Din
);

  localparam int              BW    = $clog2(C_MAX_BURST + 1);
  localparam logic [BW-1:0]   MAX_B = BW'(C_MAX_BURST);

  // Family string only documents the target; nothing depends on it.
  logic unused_family;
  assign unused_family = |C_FAMILY;

  arb_state_e    state_q, state_d;
  logic          last_owner_q, last_owner_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;

  logic [1:0]    gnt_raw;
  logic [1:0]    gnt;
  logic          xfer;
  logic          xfer_owner;
  logic          cur_owner;

  logic [0:C_NUM_WE-1]      we_sel;
  logic [0:C_PORT_AWIDTH-1] addr_sel;
  logic [0:C_PORT_DWIDTH-1] wdata_sel;

  logic                     en_q;
  logic [0:C_NUM_WE-1]      wen_q;
  logic [0:C_PORT_AWIDTH-1] addr_q;
  logic [0:C_PORT_DWIDTH-1] dout_q;

  rd_tag_t tag_in, tag1_q, tag2_q;

  mis603_soc_bram_arb_rr #(
    .C_MAX_BURST (C_MAX_BURST),
    .BW          (BW)
  ) u_rr (
    .req_i        ({M1_Req, M0_Req}),
    .state_i      (state_q),
    .last_owner_i (last_owner_q),
    .burst_cnt_i  (burst_cnt_q),
    .gnt_o        (gnt_raw)
  );

  // No grant may escape while reset is held, even though the picker is combinational.
  assign gnt        = gnt_raw & {2{BRAM_Rst_N}};
  assign M0_Gnt     = gnt[0];
  assign M1_Gnt     = gnt[1];
  assign xfer       = (M0_Req & gnt[0]) | (M1_Req & gnt[1]);
  assign xfer_owner = gnt[1] ? OWNER_M1 : OWNER_M0;
  assign cur_owner  = (state_q == ST_OWN_M1) ? OWNER_M1 : OWNER_M0;

  assign we_sel    = gnt[1] ? M1_WE    : M0_WE;
  assign addr_sel  = gnt[1] ? M1_Addr  : M0_Addr;
  assign wdata_sel = gnt[1] ? M1_WData : M0_WData;

  // Next ownership state, burst length and last owner from this cycle's transfer.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    case (state_q)
      ST_OWN_M0, ST_OWN_M1: begin
        if (!xfer) begin
          state_d = ST_IDLE;
        end else if (xfer_owner == cur_owner) begin
          if (burst_cnt_q != MAX_B) begin
            burst_cnt_d = burst_cnt_q + BW'(1);
          end
        end else begin
          state_d     = (xfer_owner == OWNER_M1) ? ST_OWN_M1 : ST_OWN_M0;
          burst_cnt_d = BW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        if (xfer) begin
          state_d     = (xfer_owner == OWNER_M1) ? ST_OWN_M1 : ST_OWN_M0;
          burst_cnt_d = BW'(1);
        end
      end
    endcase
    if (xfer) begin
      last_owner_d = xfer_owner;
    end
  end

  // Arbitration state registers; M1 counts as last owner so M0 wins the first tie.
  always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
    if (!BRAM_Rst_N) begin
      state_q      <= ST_IDLE;
      last_owner_q <= OWNER_M1;
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  // Registered BRAM drive; address and data hold when idle, enables drop.
  always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
    if (!BRAM_Rst_N) begin
      en_q   <= 1'b0;
      wen_q  <= '0;
      addr_q <= '0;
      dout_q <= '0;
    end else begin
      en_q  <= xfer;
      wen_q <= xfer ? we_sel : '0;
      if (xfer) begin
        addr_q <= addr_sel;
        dout_q <= wdata_sel;
      end
    end
  end

  assign BRAM_EN   = en_q;
  assign BRAM_WEN  = wen_q;
  assign BRAM_Addr = addr_q;
  assign BRAM_Dout = dout_q;

  always_comb begin
    tag_in.vld   = xfer && (we_sel == '0);
    tag_in.owner = xfer_owner;
  end

  // Two-stage read tag pipe lines RValid up with BRAM_Din; reset drops in-flight reads.
  always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
    if (!BRAM_Rst_N) begin
      tag1_q <= '0;
      tag2_q <= '0;
    end else begin
      tag1_q <= tag_in;
      tag2_q <= tag1_q;
    end
  end

  assign M0_RValid = tag2_q.vld && (tag2_q.owner == OWNER_M0);
  assign M1_RValid = tag2_q.vld && (tag2_q.owner == OWNER_M1);
  assign M0_RData  = BRAM_Din;
  assign M1_RData  = BRAM_Din;

endmodule

// File: tb/tb_mis603_soc_bram_port_arbiter.sv
// Bench for the BRAM port-B arbiter: directed scenarios plus random traffic vs. a history-based model.
// Latency: checks controls one cycle and read data two cycles after each grant.
// Backpressure: requesters hold a transaction until granted, sometimes drop Req while waiting.
module tb_mis603_soc_bram_port_arbiter;

  localparam int AW = 32, DW = 32, NWE = 4, MAXB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           m0_req, m1_req;
  logic [0:NWE-1] m0_we, m1_we;
  logic [0:AW-1]  m0_addr, m1_addr;
  logic [0:DW-1]  m0_wdata, m1_wdata;
  logic           m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [0:DW-1]  m0_rdata, m1_rdata;
  logic           bram_en;
  logic [0:NWE-1] bram_wen;
  logic [0:AW-1]  bram_addr;
  logic [0:DW-1]  bram_dout, bram_din;

  mis603_soc_bram_port_arbiter #(
    .C_PORT_AWIDTH(AW), .C_PORT_DWIDTH(DW), .C_NUM_WE(NWE), .C_MAX_BURST(MAXB), .C_FAMILY("spartan6")
  ) dut (
    .BRAM_Clk(clk), .BRAM_Rst_N(rst_n),
    .M0_Req(m0_req), .M0_WE(m0_we), .M0_Addr(m0_addr), .M0_WData(m0_wdata),
    .M0_Gnt(m0_gnt), .M0_RValid(m0_rvalid), .M0_RData(m0_rdata),
    .M1_Req(m1_req), .M1_WE(m1_we), .M1_Addr(m1_addr), .M1_WData(m1_wdata),
    .M1_Gnt(m1_gnt), .M1_RValid(m1_rvalid), .M1_RData(m1_rdata),
    .BRAM_EN(bram_en), .BRAM_WEN(bram_wen), .BRAM_Addr(bram_addr),
    .BRAM_Dout(bram_dout), .BRAM_Din(bram_din)
  );

  // Behavioural BRAM: 64 words, read-first, data one cycle after enable.
  logic [31:0] bmem [0:63];
  always @(posedge clk) begin
    logic [31:0] a, d;
    a = bram_addr;
    d = bram_dout;
    if (bram_en) begin
      bram_din <= bmem[a[7:2]];
      for (int i = 0; i < 4; i++)
        if (bram_wen[i]) bmem[a[7:2]][31-8*i -: 8] <= d[31-8*i -: 8];
    end
  end

  typedef struct { logic [3:0] we; logic [31:0] addr; logic [31:0] wdata; } txn_t;
  typedef struct { int due; int own; logic [31:0] data; } rv_t;
  typedef struct { int c; int o; logic [31:0] d; } rvlog_t;

  txn_t        q0[$], q1[$];
  rv_t         rvq[$];
  rvlog_t      rv_log[$];
  int          gnt_log[$];
  logic [31:0] rmem [0:63];

  int          prev_own, streak, last_own;
  logic        exp_en;
  logic [3:0]  exp_wen;
  logic [31:0] exp_addr, exp_dout;
  logic [31:0] last_rd0, last_rd1;
  int          n_rv0, n_rv1;
  int          cyc, total, bad;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // Grant rule in terms of history: who was granted last cycle and for how many cycles in a row.
  function automatic int model_pick(input bit r0, input bit r1);
    if (!r0 && !r1) return -1;
    if (r0 && !r1)  return 0;
    if (r1 && !r0)  return 1;
    if (prev_own < 0) return 1 - last_own;
    if (streak < MAXB) return prev_own;
    return 1 - prev_own;
  endfunction

  task automatic model_reset();
    prev_own = -1; streak = 0; last_own = 1;
    rvq.delete();
    exp_en = 1'b0; exp_wen = '0; exp_addr = '0; exp_dout = '0;
  endtask

  task automatic ref_write(input txn_t t);
    for (int i = 0; i < 4; i++)
      if (t.we[3-i]) rmem[t.addr[7:2]][31-8*i -: 8] = t.wdata[31-8*i -: 8];
  endtask

  function automatic txn_t mk(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata;
    return t;
  endfunction

  function automatic txn_t rand_txn();
    int k;
    logic [3:0] w;
    k = $urandom_range(0, 3);
    w = 4'($urandom);
    return mk((k < 2) ? 4'h0 : (k == 2) ? 4'hF : w, {24'h0, 6'($urandom), 2'b00}, $urandom);
  endfunction

  // One cycle: check outputs of earlier grants, drive requests, check and apply this cycle's grant.
  task automatic step(input int drop_pct);
    rv_t r;
    txn_t t;
    bit r0, r1, e0, e1;
    logic [31:0] d0, d1;
    int g;
    @(negedge clk);
    cyc++;
    check("bram_en", bram_en, exp_en);
    check("bram_wen", bram_wen, exp_wen);
    check("bram_addr", bram_addr, exp_addr);
    check("bram_dout", bram_dout, exp_dout);
    e0 = 0; e1 = 0; d0 = '0; d1 = '0;
    if (rvq.size() > 0 && rvq[0].due == cyc) begin
      r = rvq.pop_front();
      if (r.own == 0) begin e0 = 1; d0 = r.data; end
      else begin e1 = 1; d1 = r.data; end
    end
    check("rvalid0", m0_rvalid, e0);
    check("rvalid1", m1_rvalid, e1);
    if (e0 && m0_rvalid) check("rdata0", m0_rdata, d0);
    if (e1 && m1_rvalid) check("rdata1", m1_rdata, d1);
    if (m0_rvalid) begin last_rd0 = m0_rdata; n_rv0++; rv_log.push_back('{cyc, 0, m0_rdata}); end
    if (m1_rvalid) begin last_rd1 = m1_rdata; n_rv1++; rv_log.push_back('{cyc, 1, m1_rdata}); end

    r0 = (q0.size() > 0) && ($urandom_range(0, 99) >= drop_pct);
    r1 = (q1.size() > 0) && ($urandom_range(0, 99) >= drop_pct);
    m0_req = r0; m1_req = r1;
    if (q0.size() > 0) begin m0_we = q0[0].we; m0_addr = q0[0].addr; m0_wdata = q0[0].wdata; end
    if (q1.size() > 0) begin m1_we = q1[0].we; m1_addr = q1[0].addr; m1_wdata = q1[0].wdata; end
    #1;
    g = model_pick(r0, r1);
    check("gnt0", m0_gnt, g == 0);
    check("gnt1", m1_gnt, g == 1);
    if (g < 0) begin
      prev_own = -1; streak = 0; exp_en = 1'b0; exp_wen = '0;
    end else begin
      t = (g == 0) ? q0.pop_front() : q1.pop_front();
      streak = (g == prev_own) ? streak + 1 : 1;
      prev_own = g; last_own = g;
      exp_en = 1'b1; exp_wen = t.we; exp_addr = t.addr; exp_dout = t.wdata;
      gnt_log.push_back(g);
      if (t.we == 4'h0) rvq.push_back('{cyc + 2, g, rmem[t.addr[7:2]]});
      else ref_write(t);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + rvq.size()) > 0 && n < 200) begin step(0); n++; end
    check("drain_timeout", q0.size() + q1.size() + rvq.size(), 0);
    step(0);
  endtask

  // Assert reset now (requests raised to prove no grant leaks), release on the next falling edge.
  task automatic do_reset();
    rst_n = 1'b0; m0_req = 1'b1; m1_req = 1'b1;
    #1;
    check("rst_gnt0", m0_gnt, 0);
    check("rst_gnt1", m1_gnt, 0);
    check("rst_en", bram_en, 0);
    check("rst_wen", bram_wen, 0);
    check("rst_addr", bram_addr, 0);
    check("rst_dout", bram_dout, 0);
    check("rst_rv0", m0_rvalid, 0);
    check("rst_rv1", m1_rvalid, 0);
    m0_req = 1'b0; m1_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q0.delete(); q1.delete();
    model_reset();
  endtask

  initial begin
    int base, rvb;
    total = 0; bad = 0; cyc = 0; n_rv0 = 0; n_rv1 = 0;
    last_rd0 = '0; last_rd1 = '0;
    rst_n = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    m0_we = '0; m1_we = '0; m0_addr = '0; m1_addr = '0; m0_wdata = '0; m1_wdata = '0;
    for (int i = 0; i < 64; i++) rmem[i] = $urandom;
    rmem[0] = 32'h11111111; rmem[1] = 32'h22222222; rmem[2] = 32'h33333333;
    rmem[4] = 32'hDEADBEEF; rmem[12] = 32'h00000000;
    for (int i = 0; i < 64; i++) bmem[i] = rmem[i];
    model_reset();
    repeat (2) @(negedge clk);
    do_reset();

    // Lone M0 read of preloaded word.
    q0.push_back(mk(4'h0, 32'h10, 32'h0));
    drain();
    check("m0_rd_deadbeef", last_rd0, 32'hDEADBEEF);

    // M1 full write then readback; the write must not raise RValid.
    rvb = n_rv1;
    q1.push_back(mk(4'hF, 32'h20, 32'h12345678));
    q1.push_back(mk(4'h0, 32'h20, 32'h0));
    drain();
    check("m1_rd_back", last_rd1, 32'h12345678);
    check("m1_rv_count", n_rv1 - rvb, 1);

    // Single-byte write merges into a zero word.
    q0.push_back(mk(4'b0100, 32'h30, 32'hAABBCCDD));
    q0.push_back(mk(4'h0, 32'h30, 32'h0));
    drain();
    check("byte_write", last_rd0, 32'h00BB0000);

    // Back-to-back reads alternating owner.
    q0.push_back(mk(4'h0, 32'h0, 32'h0)); step(0);
    q1.push_back(mk(4'h0, 32'h4, 32'h0)); step(0);
    q0.push_back(mk(4'h0, 32'h8, 32'h0)); step(0);
    drain();
    base = rv_log.size() - 3;
    check("il_own0", rv_log[base].o, 0);
    check("il_own1", rv_log[base+1].o, 1);
    check("il_own2", rv_log[base+2].o, 0);
    check("il_adj01", rv_log[base+1].c - rv_log[base].c, 1);
    check("il_adj12", rv_log[base+2].c - rv_log[base+1].c, 1);
    check("il_d0", rv_log[base].d, 32'h11111111);
    check("il_d1", rv_log[base+1].d, 32'h22222222);
    check("il_d2", rv_log[base+2].d, 32'h33333333);

    // Continuous contention from reset: bursts of MAXB per owner.
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 12; i++) begin
      q0.push_back(mk(4'h0, 32'(4 * i), 32'h0));
      q1.push_back(mk(4'h0, 32'(4 * i + 64), 32'h0));
    end
    base = gnt_log.size();
    repeat (12) step(0);
    check("burst_count", gnt_log.size() - base, 12);
    for (int i = 0; i < 12; i++) check("burst_pat", gnt_log[base + i], (i / MAXB) % 2);
    drain();

    // Random traffic with occasional Req drops while waiting.
    for (int n = 0; n < 3000; n++) begin
      if (q0.size() < 3 && $urandom_range(0, 2) == 0) q0.push_back(rand_txn());
      if (q1.size() < 3 && $urandom_range(0, 2) == 0) q1.push_back(rand_txn());
      step(15);
    end
    drain();

    // Reset in the cycle after a read grant: read is lost, arbitration restarts.
    q0.push_back(mk(4'h0, 32'h10, 32'h0));
    step(0);
    @(negedge clk);
    check("mid_en_before", bram_en, 1);
    rvb = n_rv0;
    do_reset();
    repeat (4) step(0);
    check("mid_no_rvalid", n_rv0 - rvb, 0);
    q0.push_back(mk(4'h0, 32'h0, 32'h0));
    q1.push_back(mk(4'h0, 32'h4, 32'h0));
    step(0);
    check("mid_first_tie", gnt_log[gnt_log.size() - 1], 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
